// File: rtl/aes_128_pkg.sv
// rtl/aes_128_pkg.sv - shared constants for the AES-128 controller slice
package aes_128_pkg;

  // Controller state encoding
  localparam logic [2:0] CTRL_IDLE      = 3'd0;
  localparam logic [2:0] CTRL_KEY_START = 3'd1;
  localparam logic [2:0] CTRL_KEY_WAIT  = 3'd2;
  localparam logic [2:0] CTRL_ENC_START = 3'd3;
  localparam logic [2:0] CTRL_ENC_WAIT  = 3'd4;

  // Shared S-box owner select
  localparam logic SBOX_SEL_KEY = 1'b0;
  localparam logic SBOX_SEL_ENC = 1'b1;

  // Default watchdog limit in wait cycles per phase
  localparam int unsigned AES_128_WDT_LIMIT = 64;

endpackage

// File: rtl/aes_128_ctrl_wdt.sv
// rtl/aes_128_ctrl_wdt.sv - saturating wait-cycle watchdog, used only with AES_128_CTRL_WDT_EN
module aes_128_ctrl_wdt
  import aes_128_pkg::*;
#(
  parameter int unsigned LIMIT = AES_128_WDT_LIMIT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT) + 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Expiry fires on the edge that completes the LIMIT-th wait cycle
  assign expired = (count_q >= LAST);

  // Count enabled cycles, saturating once expired so the flag cannot wrap away
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !expired) begin
      count_d = count_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/aes_128_ctrl.sv
// rtl/aes_128_ctrl.sv - AES-128 command sequencer and shared S-box owner; watchdog via AES_128_CTRL_WDT_EN
module aes_128_ctrl
  import aes_128_pkg::*;
#(
  parameter int unsigned WDT_LIMIT = AES_128_WDT_LIMIT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        init,
  input  logic        next,
  input  logic        key_mem_ready,
  input  logic        enc_ready,
  input  logic [31:0] key_mem_sbox,
  input  logic [31:0] enc_sbox,
  output logic        key_mem_init,
  output logic        enc_next,
  output logic        sbox_sel,
  output logic [31:0] sbox_in,
  output logic        ready,
  output logic        key_valid,
  output logic        result_valid,
  output logic        error
);

  logic [2:0] state_q, state_d;
  logic       guard_q, guard_d;
  logic       key_valid_q, key_valid_d;
  logic       result_valid_q, result_valid_d;
  logic       sbox_sel_q, sbox_sel_d;

`ifdef AES_128_CTRL_WDT_EN
  logic error_q, error_d;
  logic wdt_en;
  logic wdt_expired;

  assign wdt_en = (state_q == CTRL_KEY_WAIT) || (state_q == CTRL_ENC_WAIT);

  aes_128_ctrl_wdt #(
    .LIMIT (WDT_LIMIT)
  ) u_wdt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!wdt_en),
    .en      (wdt_en),
    .expired (wdt_expired)
  );

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  // Start pulses are pure state decodes so they last exactly one cycle
  assign key_mem_init = (state_q == CTRL_KEY_START);
  assign enc_next     = (state_q == CTRL_ENC_START);
  assign ready        = (state_q == CTRL_IDLE);
  assign key_valid    = key_valid_q;
  assign result_valid = result_valid_q;
  assign sbox_sel     = sbox_sel_q;
  assign sbox_in      = (sbox_sel_q == SBOX_SEL_ENC) ? enc_sbox : key_mem_sbox;

  // Next-state logic; the guard cycle masks the stale ready still high from the previous phase
  always_comb begin
    state_d        = state_q;
    guard_d        = guard_q;
    key_valid_d    = key_valid_q;
    result_valid_d = result_valid_q;
    sbox_sel_d     = sbox_sel_q;
`ifdef AES_128_CTRL_WDT_EN
    error_d        = error_q;
`endif
    case (state_q)
      CTRL_IDLE: begin
        if (init) begin
          state_d        = CTRL_KEY_START;
          key_valid_d    = 1'b0;
          result_valid_d = 1'b0;
          sbox_sel_d     = SBOX_SEL_KEY;
`ifdef AES_128_CTRL_WDT_EN
          error_d        = 1'b0;
`endif
        end else if (next && key_valid_q) begin
          state_d        = CTRL_ENC_START;
          result_valid_d = 1'b0;
          sbox_sel_d     = SBOX_SEL_ENC;
`ifdef AES_128_CTRL_WDT_EN
          error_d        = 1'b0;
`endif
        end
      end
      CTRL_KEY_START: begin
        state_d = CTRL_KEY_WAIT;
        guard_d = 1'b1;
      end
      CTRL_ENC_START: begin
        state_d = CTRL_ENC_WAIT;
        guard_d = 1'b1;
      end
      CTRL_KEY_WAIT, CTRL_ENC_WAIT: begin
        if (guard_q) begin
          guard_d = 1'b0;
        end else if ((state_q == CTRL_KEY_WAIT) ? key_mem_ready : enc_ready) begin
          state_d    = CTRL_IDLE;
          sbox_sel_d = SBOX_SEL_KEY;
          if (state_q == CTRL_KEY_WAIT) begin
            key_valid_d = 1'b1;
          end else begin
            result_valid_d = 1'b1;
          end
`ifdef AES_128_CTRL_WDT_EN
        end else if (wdt_expired) begin
          state_d    = CTRL_IDLE;
          sbox_sel_d = SBOX_SEL_KEY;
          error_d    = 1'b1;
`endif
        end
      end
      default: begin
        state_d    = CTRL_IDLE;
        sbox_sel_d = SBOX_SEL_KEY;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= CTRL_IDLE;
      guard_q        <= 1'b0;
      key_valid_q    <= 1'b0;
      result_valid_q <= 1'b0;
      sbox_sel_q     <= SBOX_SEL_KEY;
`ifdef AES_128_CTRL_WDT_EN
      error_q        <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      guard_q        <= guard_d;
      key_valid_q    <= key_valid_d;
      result_valid_q <= result_valid_d;
      sbox_sel_q     <= sbox_sel_d;
`ifdef AES_128_CTRL_WDT_EN
      error_q        <= error_d;
`endif
    end
  end

endmodule
